// File: rtl/tile_reset_sequencer.sv
// tile_reset_sequencer
// Drives the reset of one tile so that the tile never sees reset while it
// still has TileLink transactions in flight:
//   RUN -> DRAIN (block new A/C traffic and wait for outstanding D responses)
//       -> HOLD  (tile_reset high for HOLD_CYCLES cycles)
//       -> RELEASE (one cycle with reset low and traffic still blocked)
//       -> RUN   (done pulses for one cycle)
// Global reset drops straight into HOLD, so the tile also gets a full
// HOLD_CYCLES reset pulse after power-up.
//
// Ports
//   clock        : sole clock
//   reset        : asynchronous, active-high
//   req_reset    : request to reset the tile (looked at in RUN only)
//   a_fire       : A-channel handshake that expects a D response
//   c_rel_fire   : last beat of a C-channel Release (expects ReleaseAck)
//   d_last_fire  : last beat of a D response (closes one transaction)
//   a_block      : gates the tile A and C valids while high
//   tile_reset   : reset to the tile
//   state        : 0=RUN 1=DRAIN 2=HOLD 3=RELEASE
//   done         : one-cycle pulse on return to RUN
//   timeout_err  : sticky, drain timeout or outstanding-counter overflow
//   outstanding  : current outstanding-transaction count
module tile_reset_sequencer #(
    parameter int CNT_W         = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_reset,
    input  logic             a_fire,
    input  logic             c_rel_fire,
    input  logic             d_last_fire,
    output logic             a_block,
    output logic             tile_reset,
    output logic [1:0]       state,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] outstanding
);

    localparam int SUM_W = CNT_W + 2;
    localparam int HLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [HLD_W-1:0] HOLD_INIT = HLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [HLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TMR_W-1:0]   drain_tmr_q, drain_tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               a_block_q, a_block_d;
    logic               tile_reset_q, tile_reset_d;

    logic [SUM_W-1:0]   cnt_sum;
    logic [CNT_W-1:0]   cnt_next;
    logic               cnt_ovf;

    // Outstanding counter: both increments and the decrement are netted in
    // a wider sum so a simultaneous +1/-1 never touches the saturation or
    // floor logic. HOLD clears the count and ignores the fire inputs.
    always_comb begin
        cnt_sum = {2'b00, cnt_q} + SUM_W'(a_fire) + SUM_W'(c_rel_fire);
        if (d_last_fire && (cnt_sum != '0)) begin
            cnt_sum = cnt_sum - SUM_W'(1);
        end
        cnt_ovf  = 1'b0;
        cnt_next = cnt_sum[CNT_W-1:0];
        if (cnt_sum > {2'b00, CNT_MAX}) begin
            cnt_ovf  = 1'b1;
            cnt_next = CNT_MAX;
        end
        if (state_q == ST_HOLD) begin
            cnt_ovf  = 1'b0;
            cnt_next = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        drain_tmr_d = '0;
        err_d       = err_q | cnt_ovf;

        case (state_q)
            ST_RUN: begin
                if (req_reset) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the count will be zero next cycle, so the
                // tile is reset the cycle after the last response closes.
                if (cnt_next == '0) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_INIT;
                end else if (drain_tmr_q == TMR_LAST) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_INIT;
                    err_d      = 1'b1;
                end else begin
                    drain_tmr_d = drain_tmr_q + TMR_W'(1);
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HLD_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state output on the same cycle.
        cnt_d        = (state_d == ST_HOLD) ? '0 : cnt_next;
        done_d       = (state_q == ST_RELEASE);
        a_block_d    = (state_d != ST_RUN);
        tile_reset_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= HOLD_INIT;
            drain_tmr_q  <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            a_block_q    <= 1'b1;
            tile_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            drain_tmr_q  <= drain_tmr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            done_q       <= done_d;
            a_block_q    <= a_block_d;
            tile_reset_q <= tile_reset_d;
        end
    end

    assign state       = state_q;
    assign a_block     = a_block_q;
    assign tile_reset  = tile_reset_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign outstanding = cnt_q;

endmodule

// File: tb/tb_tile_reset_sequencer.sv
// Bench for tile_reset_sequencer. Two instances: one with default
// parameters, one with CNT_W=2 / DRAIN_TIMEOUT=8. The stimulus driver pushes
// the expected post-edge outputs into a queue for every cycle it drives; a
// monitor pops one entry after each rising edge and compares.
module tb_tile_reset_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic a0 = 1'b0, c0 = 1'b0, d0 = 1'b0, r0 = 1'b0;
    logic a1 = 1'b0, c1 = 1'b0, d1 = 1'b0, r1 = 1'b0;

    logic       ab0, tr0, dn0, er0;
    logic [1:0] st0;
    logic [3:0] oc0;
    logic       ab1, tr1, dn1, er1;
    logic [1:0] st1;
    logic [1:0] oc1;

    tile_reset_sequencer dut0 (
        .clock(clk), .reset(rst), .req_reset(r0), .a_fire(a0),
        .c_rel_fire(c0), .d_last_fire(d0), .a_block(ab0), .tile_reset(tr0),
        .state(st0), .done(dn0), .timeout_err(er0), .outstanding(oc0)
    );

    tile_reset_sequencer #(.CNT_W(2), .HOLD_CYCLES(16), .DRAIN_TIMEOUT(8)) dut1 (
        .clock(clk), .reset(rst), .req_reset(r1), .a_fire(a1),
        .c_rel_fire(c1), .d_last_fire(d1), .a_block(ab1), .tile_reset(tr1),
        .state(st1), .done(dn1), .timeout_err(er1), .outstanding(oc1)
    );

    typedef struct {
        bit    sel;
        string tag;
        int    st, tr, ab, dn, er, oc;
    } exp_t;

    exp_t sb[$];
    bit   cur = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".state"},  e.sel ? int'(st1) : int'(st0), e.st);
            chk({e.tag, ".trst"},   e.sel ? int'(tr1) : int'(tr0), e.tr);
            chk({e.tag, ".ablk"},   e.sel ? int'(ab1) : int'(ab0), e.ab);
            chk({e.tag, ".done"},   e.sel ? int'(dn1) : int'(dn0), e.dn);
            chk({e.tag, ".err"},    e.sel ? int'(er1) : int'(er0), e.er);
            chk({e.tag, ".outst"},  e.sel ? int'(oc1) : int'(oc0), e.oc);
        end
    end

    // Drive one cycle of inputs on the selected instance and queue what it
    // must show after the next rising edge. Called at a falling edge.
    task automatic tick(input bit a, input bit c, input bit d, input bit r,
                        input int st, input int tr, input int ab, input int dn,
                        input int er, input int oc, input string tag);
        exp_t e;
        a0 = cur ? 1'b0 : a; c0 = cur ? 1'b0 : c; d0 = cur ? 1'b0 : d; r0 = cur ? 1'b0 : r;
        a1 = cur ? a : 1'b0; c1 = cur ? c : 1'b0; d1 = cur ? d : 1'b0; r1 = cur ? r : 1'b0;
        e.sel = cur; e.tag = tag;
        e.st = st; e.tr = tr; e.ab = ab; e.dn = dn; e.er = er; e.oc = oc;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Remainder of a HOLD whose first cycle has already been observed:
    // 15 more HOLD cycles, one RELEASE, then RUN with done.
    task automatic hold_rest(input bit fire, input bit r, input int er, input string tag);
        for (int i = 0; i < 15; i++) tick(fire, fire, 1'b0, r, 2, 1, 1, 0, er, 0, {tag, ".hold"});
        tick(1'b0, 1'b0, 1'b0, r, 3, 0, 1, 0, er, 0, {tag, ".rel"});
        tick(1'b0, 1'b0, 1'b0, r, 0, 0, 0, 1, er, 0, {tag, ".run"});
    endtask

    task automatic check_async_reset(input string tag);
        chk({tag, ".state0"}, int'(st0), 2);
        chk({tag, ".trst0"},  int'(tr0), 1);
        chk({tag, ".ablk0"},  int'(ab0), 1);
        chk({tag, ".done0"},  int'(dn0), 0);
        chk({tag, ".err0"},   int'(er0), 0);
        chk({tag, ".outst0"}, int'(oc0), 0);
        chk({tag, ".state1"}, int'(st1), 2);
        chk({tag, ".err1"},   int'(er1), 0);
        chk({tag, ".outst1"}, int'(oc1), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog sb_left=%0d exp=0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up: reset asserted from time 0, checked between edges.
        @(negedge clk);
        #1;
        check_async_reset("por");
        @(negedge clk);
        rst = 1'b0;
        cur = 1'b0;
        hold_rest(1'b0, 1'b0, 0, "por");
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "por.idle");

        // Clean drain: three requests, reset request, responses 5 cycles apart.
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "drn.a1");
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, "drn.a2");
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, "drn.a3");
        tick(0, 0, 0, 1, 1, 0, 1, 0, 0, 3, "drn.req");
        for (int k = 3; k >= 2; k--) begin
            for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1, 0, 1, 0, 0, k, "drn.wait");
            tick(0, 0, 1, 0, 1, 0, 1, 0, 0, k - 1, "drn.d");
        end
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, "drn.wait");
        tick(0, 0, 1, 0, 2, 1, 1, 0, 0, 0, "drn.last");
        hold_rest(1'b1, 1'b1, 0, "drn");

        // Netting of simultaneous events.
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "net.a1");
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, "net.a2");
        tick(1, 0, 1, 0, 0, 0, 0, 0, 0, 2, "net.ad");
        tick(0, 1, 0, 0, 0, 0, 0, 0, 0, 3, "net.c");
        tick(1, 1, 1, 0, 0, 0, 0, 0, 0, 4, "net.acd");
        for (int k = 3; k >= 0; k--) tick(0, 0, 1, 0, 0, 0, 0, 0, 0, k, "net.d");
        tick(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "net.d_at0");

        // req_reset held across a whole sequence restarts one cycle after done.
        tick(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, "held.req");
        tick(0, 0, 0, 1, 2, 1, 1, 0, 0, 0, "held.hold1");
        hold_rest(1'b0, 1'b1, 0, "held");
        tick(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, "held.redrain");
        tick(0, 0, 0, 0, 2, 1, 1, 0, 0, 0, "held.hold2");

        // Reset during the fifth HOLD cycle restarts the full HOLD.
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 2, 1, 1, 0, 0, 0, "mid.hold");
        rst = 1'b1;
        #1;
        check_async_reset("mid");
        @(negedge clk);
        rst = 1'b0;
        hold_rest(1'b0, 1'b0, 0, "mid");

        // Drain timeout on the small instance.
        cur = 1'b1;
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "to.a");
        tick(0, 0, 0, 1, 1, 0, 1, 0, 0, 1, "to.req");
        for (int i = 0; i < 7; i++) tick(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, "to.drain");
        tick(0, 0, 0, 0, 2, 1, 1, 0, 1, 0, "to.hold");
        hold_rest(1'b0, 1'b0, 1, "to");
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "to.sticky");

        // Only reset clears the sticky error.
        rst = 1'b1;
        #1;
        check_async_reset("clr");
        @(negedge clk);
        rst = 1'b0;
        hold_rest(1'b0, 1'b0, 0, "clr");

        // Counter saturation and floor.
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "sat.a1");
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, "sat.a2");
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, "sat.a3");
        tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, "sat.a4");
        for (int k = 2; k >= 0; k--) tick(0, 0, 1, 0, 0, 0, 0, 0, 1, k, "sat.d");
        tick(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, "sat.d_at0");

        a1 = 1'b0; c1 = 1'b0; d1 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tile_reset_sequencer.md
TILE_RESET_SEQUENCER -- requirements
Module: tile_reset_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the outstanding-transaction counter.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: number of cycles tile_reset is held (>=2).
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 1024: maximum number of DRAIN cycles before a forced reset.
REQ-004 SHALL have port clock, input, 1: sole clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-006 SHALL have port req_reset, input, 1: request to reset the tile; level-sampled in RUN only.
REQ-007 SHALL have port a_fire, input, 1: tile A-channel valid&ready (a request that expects a D response).
REQ-008 SHALL have port c_rel_fire, input, 1: tile C-channel Release/ReleaseData last beat (expects ReleaseAck).
REQ-009 SHALL have port d_last_fire, input, 1: D-channel last-beat valid&ready (closes one outstanding transaction).
REQ-010 SHALL have port a_block, output, 1: gates the tile A and C valid signals when 1.
REQ-011 SHALL have port tile_reset, output, 1: drives the BoomTile reset.
REQ-012 SHALL have port state, output, 2: 0=RUN, 1=DRAIN, 2=HOLD, 3=RELEASE.
REQ-013 SHALL have port done, output, 1: single-cycle pulse on return to RUN.
REQ-014 SHALL have port timeout_err, output, 1: sticky; set on drain timeout or counter overflow.
REQ-015 SHALL have port outstanding, output, CNT_W: current outstanding-transaction count.

Function
REQ-016 All outputs SHALL be registered; state transitions SHALL take effect on the cycle after the triggering condition is sampled.
REQ-017 outstanding SHALL update each cycle as follows:
- +1 for each of a_fire and c_rel_fire.
- -1 for d_last_fire.
- Simultaneous events SHALL net; for example, a_fire+d_last_fire leaves the count unchanged.
REQ-018 The counter SHALL saturate at 2^CNT_W-1; an increment attempted at max SHALL set timeout_err.
REQ-019 A decrement at 0 SHALL hold the counter at 0; this is not an error.
REQ-020 RUN: a_block=0, tile_reset=0; req_reset=1 -> DRAIN.
REQ-021 DRAIN behaviour:
- a_block=1 and tile_reset=0.
- A drain timer SHALL count from 0.
- When the next-cycle outstanding value equals 0 -> HOLD.
- When the timer reaches DRAIN_TIMEOUT-1 with outstanding nonzero -> HOLD, and timeout_err SHALL be set.
REQ-022 HOLD behaviour:
- tile_reset=1 and a_block=1.
- The hold counter SHALL load HOLD_CYCLES-1 on entry and decrement each cycle; at 0 -> RELEASE.
- outstanding SHALL be forced to 0 throughout HOLD, and fire inputs SHALL be ignored.
REQ-023 RELEASE: tile_reset=0, a_block=1 for exactly one cycle, then -> RUN with done=1 for that one cycle.
REQ-024 req_reset SHALL be ignored outside RUN; a level still high on entry to RUN SHALL start a new sequence one cycle later.
REQ-025 The total tile_reset high time SHALL be exactly HOLD_CYCLES cycles per sequence.
REQ-026 timeout_err SHALL clear only on reset.

Reset
REQ-027 Asserting reset SHALL immediately force the following, regardless of clock:
- state=HOLD with the hold counter loaded to HOLD_CYCLES-1.
- tile_reset=1, a_block=1.
- outstanding=0, done=0, timeout_err=0, drain timer=0.
REQ-028 After reset deassertion, the block SHALL complete a normal HOLD -> RELEASE -> RUN sequence, so the tile sees HOLD_CYCLES cycles of reset after global reset.
REQ-029 Reset asserted mid-DRAIN or mid-HOLD SHALL abandon the sequence and restart per REQ-027.

Verification
REQ-030 Power-up: reset released at cycle 0 -> tile_reset=1 for cycles 0..15, RELEASE at 16, done=1 and state=RUN at 17.
REQ-031 Clean drain:
- Stimulus: three a_fire while in RUN, then req_reset.
- Then three d_last_fire spaced 5 cycles apart.
- Response: state=DRAIN until outstanding reaches 0, HOLD on the following cycle, and timeout_err=0.
REQ-032 Simultaneous events: a_fire and d_last_fire in the same cycle at outstanding=2 -> outstanding stays 2; c_rel_fire alone -> 3.
REQ-033 Timeout: DRAIN_TIMEOUT=8 with outstanding=1 and no D response -> HOLD after 8 DRAIN cycles, timeout_err=1 and sticky, outstanding=0 in HOLD.
REQ-034 Saturation: CNT_W=2 with 4 a_fire -> outstanding=3 and timeout_err=1; d_last_fire at 0 -> stays 0.
REQ-035 Mid-sequence reset and held request:
- Reset pulsed during HOLD cycle 5 -> full 16-cycle HOLD restarts.
- req_reset held high through a sequence -> a new DRAIN begins one cycle after done.
